// File: rtl/note_lane_renderer_pkg.sv
// ============================================================================
// note_pkg -- colour/note-code constants, FSM encoding and slot helpers.
// Rev 1.0
// ============================================================================
`default_nettype none

package note_pkg;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] MAGENTA = 3'b101;

  localparam logic [1:0] NOTE_NONE  = 2'b00;
  localparam logic [1:0] NOTE_LEFT  = 2'b01;
  localparam logic [1:0] NOTE_RIGHT = 2'b10;
  localparam logic [1:0] NOTE_BOTH  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [2:0] note_colour(input logic [1:0] code);
    case (code)
      NOTE_LEFT:  return RED;
      NOTE_RIGHT: return BLUE;
      NOTE_BOTH:  return MAGENTA;
      default:    return BLACK;
    endcase
  endfunction

  // Slot x position is formed at 16 bits, then wraps to the 8-bit screen width.
  function automatic logic [7:0] slot_x(input int origin, input int pitch, input int idx);
    return 8'(16'(origin) + 16'(pitch) * 16'(idx));
  endfunction

endpackage

`default_nettype wire

// File: rtl/note_lane_renderer_divider.sv
// ============================================================================
// rate_divider -- free-running modulo-DIV counter with a terminal-count tick.
// Rev 1.0
// ============================================================================
`default_nettype none

module rate_divider #(
  parameter int DIV = 17
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          at_end;

  assign at_end = (count_q == CW'(DIV - 1));

  always_comb begin
    count_d = count_q;
    if (enable) begin
      count_d = at_end ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A held count at the terminal value must not keep firing while disabled.
  assign tick = enable && at_end;

endmodule

`default_nettype wire

// File: rtl/note_lane_renderer.sv
// ============================================================================
// note_lane_renderer -- per frame tick, streams one coloured square per slot.
// Rev 1.0
// ============================================================================
`default_nettype none

module note_lane_renderer
  import note_pkg::*;
#(
  parameter int NUM_SLOTS  = 10,
  parameter int SLOT_PITCH = 5,
  parameter int X_ORIGIN   = 0,
  parameter int Y_ORIGIN   = 0,
  parameter int TICK_DIV   = 17
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [2*NUM_SLOTS-1:0] notes,
  output logic                   draw_valid,
  input  logic                   draw_ready,
  output logic [7:0]             draw_x,
  output logic [6:0]             draw_y,
  output logic [2:0]             colour,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int IW = $clog2(NUM_SLOTS + 1);

  logic                   frame_tick;
  state_e                 state_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          idx_d;
  logic [2*NUM_SLOTS-1:0] snap_q;
  logic                   draw_valid_q;
  logic [7:0]             draw_x_q;
  logic [6:0]             draw_y_q;
  logic [2:0]             colour_q;
  logic                   busy_q;
  logic                   frame_done_q;
  logic                   overrun_q;
  logic                   accept;
  logic                   last_slot;

  rate_divider #(.DIV(TICK_DIV)) u_div (
    .clock  (clock),
    .resetn (resetn),
    .enable (enable),
    .tick   (frame_tick)
  );

  assign idx_d     = idx_q + IW'(1);
  assign last_slot = (idx_q == IW'(NUM_SLOTS - 1));
  assign accept    = draw_valid_q && draw_ready;

  // Outputs are loaded with the next slot's values on the same edge idx moves.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      snap_q       <= '0;
      draw_valid_q <= 1'b0;
      draw_x_q     <= '0;
      draw_y_q     <= '0;
      colour_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (frame_tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            state_q      <= ST_EMIT;
            snap_q       <= notes;
            idx_q        <= '0;
            draw_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            draw_x_q     <= slot_x(X_ORIGIN, SLOT_PITCH, 0);
            draw_y_q     <= 7'(Y_ORIGIN);
            colour_q     <= note_colour(notes[1:0]);
          end
        end
        ST_EMIT: begin
          if (accept) begin
            if (last_slot) begin
              state_q      <= ST_DONE;
              draw_valid_q <= 1'b0;
              draw_x_q     <= '0;
              draw_y_q     <= '0;
              colour_q     <= '0;
              frame_done_q <= 1'b1;
            end else begin
              idx_q    <= idx_d;
              draw_x_q <= slot_x(X_ORIGIN, SLOT_PITCH, int'(idx_d));
              colour_q <= note_colour(snap_q[2*idx_d +: 2]);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign draw_valid = draw_valid_q;
  assign draw_x     = draw_x_q;
  assign draw_y     = draw_y_q;
  assign colour     = colour_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire
